// File: rtl/spi_reg_sender.sv
// SPI mode-0 master that serialises one raybox-zero register-write frame: a 4-bit
// command followed by a command-dependent payload. Define SPI_REG_SENDER_QUEUE_EN for a 2-entry input FIFO.
module spi_reg_sender #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [3:0]  i_cmd,
    input  logic [11:0] i_data,
    output logic        o_sclk,
    output logic        o_ss_n,
    output logic        o_mosi,
    output logic        o_busy,
    output logic        o_done
);
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
    } state_t;

    state_t          state;
    logic [15:0]     shreg;
    logic [4:0]      bit_cnt;
    logic [4:0]      n_bits;
    logic [HW-1:0]   half_cnt;
    logic [GW-1:0]   gap_cnt;

    logic            half_done;
    logic            gap_done;
    logic            load_en;
    logic [15:0]     load_word;
    logic [15:0]     load_shreg;
    logic [4:0]      load_bits;

    // Left-align the frame so shreg[15] is always the next bit on the wire.
    function automatic logic [15:0] frame_word(input logic [3:0] cmd, input logic [11:0] data);
        case (cmd)
            4'd0, 4'd1, 4'd2, 4'd4: frame_word = {cmd, data[5:0], 6'b0};
            4'd3:                   frame_word = {cmd, data};
            default:                frame_word = {cmd, data[0], 11'b0};
        endcase
    endfunction

    function automatic logic [4:0] frame_bits(input logic [3:0] cmd);
        case (cmd)
            4'd0, 4'd1, 4'd2, 4'd4: frame_bits = 5'd10;
            4'd3:                   frame_bits = 5'd16;
            default:                frame_bits = 5'd5;
        endcase
    endfunction

    assign half_done  = (half_cnt == HALF_LAST);
    assign gap_done   = (gap_cnt == GAP_LAST);
    assign load_shreg = frame_word(load_word[15:12], load_word[11:0]);
    assign load_bits  = frame_bits(load_word[15:12]);

    // Handshake: a frame is transferred on a rising clk edge where i_valid && o_ready;
    // i_cmd/i_data are only sampled on that edge and may change afterwards.
`ifdef SPI_REG_SENDER_QUEUE_EN
    logic [15:0] fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_cnt;
    logic        fifo_empty;
    logic        take;
    logic        push;
    logic        pop;

    assign fifo_empty = (fifo_cnt == 2'd0);
    assign o_ready    = (fifo_cnt != 2'd2);
    assign take       = (state == S_IDLE) || (state == S_GAP && gap_done);
    assign load_en    = take && (!fifo_empty || i_valid);
    assign load_word  = fifo_empty ? {i_cmd, i_data} : fifo_mem[rd_ptr];
    assign pop        = take && !fifo_empty;
    // An empty FIFO is bypassed so an idle sender starts on the next edge.
    assign push       = i_valid && o_ready && !(take && fifo_empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {i_cmd, i_data};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (push && !pop)
                fifo_cnt <= fifo_cnt + 2'd1;
            else if (pop && !push)
                fifo_cnt <= fifo_cnt - 2'd1;
        end
    end
`else
    assign o_ready   = (state == S_IDLE);
    assign load_en   = (state == S_IDLE) && i_valid;
    assign load_word = {i_cmd, i_data};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            shreg    <= 16'd0;
            bit_cnt  <= 5'd0;
            n_bits   <= 5'd0;
            half_cnt <= '0;
            gap_cnt  <= '0;
            o_sclk   <= 1'b0;
            o_ss_n   <= 1'b1;
            o_mosi   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_en) begin
                        state    <= S_SETUP;
                        shreg    <= load_shreg;
                        n_bits   <= load_bits;
                        bit_cnt  <= 5'd0;
                        half_cnt <= '0;
                        o_ss_n   <= 1'b0;
                        o_mosi   <= load_shreg[15];
                        o_busy   <= 1'b1;
                    end
                end
                S_SETUP, S_LOW: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        state    <= S_HIGH;
                        o_sclk   <= 1'b1;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        o_sclk   <= 1'b0;
                        if (bit_cnt == n_bits - 5'd1) begin
                            state <= S_HOLD;
                        end else begin
                            state   <= S_LOW;
                            bit_cnt <= bit_cnt + 5'd1;
                            shreg   <= {shreg[14:0], 1'b0};
                            o_mosi  <= shreg[14];
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        gap_cnt  <= '0;
                        state    <= S_GAP;
                        o_ss_n   <= 1'b1;
                        o_mosi   <= 1'b0;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        gap_cnt <= '0;
                        o_done  <= 1'b1;
                        if (load_en) begin
                            state    <= S_SETUP;
                            shreg    <= load_shreg;
                            n_bits   <= load_bits;
                            bit_cnt  <= 5'd0;
                            half_cnt <= '0;
                            o_ss_n   <= 1'b0;
                            o_mosi   <= load_shreg[15];
                        end else begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
